tmds_symbol_decoder: RTL
========================

# tmds_symbol_decoder

Receive-side counterpart to the DVI transmit path: accepts one parallel 10-bit TMDS symbol per pixel clock from a per-channel deserializer and recovers word alignment by pulsing `bitslip` until control-token runs appear. Once aligned, it decodes each symbol to 8-bit pixel data or a 2-bit control value and reports `de`. One instance per TMDS channel. Channel 0 `ctrl` carries {vsync, hsync}.

## Interface
- `CTRL_RUN`, default 8: consecutive control tokens needed to declare or keep alignment.
- `SEARCH_LEN`, default 2048: window length in cycles. It must exceed one full video line (1500 cycles at 1366x768).
- `SLIP_WAIT`, default 16: settle cycles after each bitslip before searching resumes.

Ports:
- `clk_pix`  in  1: pixel clock; the only clock.
- `rst_pix_n`  in  1: reset, asynchronous, active-low.
- `din`  in  10: TMDS symbol q[9:0]. q[0] is the first bit on the wire.
- `bitslip`  out  1: one-cycle request to the deserializer to shift word boundary by one bit.
- `locked`  out  1: alignment achieved.
- `de`  out  1: current output is a data symbol.
- `ctrl`  out  2: decoded control value.
- `dout`  out  8: decoded pixel data.

## Operation
- Control tokens, as q[9:0]:
  - 0x354 gives ctrl 00.
  - 0x0AB gives ctrl 01.
  - 0x154 gives ctrl 10.
  - 0x2AB gives ctrl 11.
  - Every other value is a data symbol.
- Data decode:
  - d' = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = d'[0].
  - For i = 1..7: d[i] = q[8] ? d'[i]^d'[i-1] : ~(d'[i]^d'[i-1]).
- Run counter:
  - Increments on a control-token cycle and clears on a data-symbol cycle.
  - Saturates at `CTRL_RUN`.
  - Cleared in WAIT.
- Window counter: counts cycles in SEARCH and LOCKED. It clears on a state change and on window expiry.
- FSM states, with reset state SEARCH:
  - SEARCH:
    - Go to LOCKED when the run counter reaches `CTRL_RUN`.
    - Otherwise, when the window reaches `SEARCH_LEN`, go to WAIT.
  - WAIT:
    - `bitslip` = 1 on the first WAIT cycle only.
    - After `SLIP_WAIT` cycles, return to SEARCH with the window and run counters at 0.
  - LOCKED:
    - Each window must contain at least one run of `CTRL_RUN` tokens; a run seen clears the window counter.
    - If the window expires without a run, go to SEARCH. No bitslip is issued on loss of lock.
- Simultaneous run completion and window expiry: the run wins (lock is gained or kept).
- Output gating:
  - While the FSM is not LOCKED (pre-edge state), `de`, `ctrl` and `dout` are forced to 0.
  - When LOCKED, a control symbol gives `de`=0, `ctrl`=value, `dout`=0.
  - When LOCKED, a data symbol gives `de`=1, `dout`=d, and `ctrl` holds its last value.
- Bitslip count is unbounded; slipping continues indefinitely until lock.

## Timing
- Reset: all outputs 0, FSM in SEARCH, all counters 0. Reset asserted mid-WAIT or mid-LOCKED returns immediately to this state.
- Decode latency is 1 cycle: `de`, `ctrl` and `dout` are registered from the `din` sampled on the same edge.
- Lock acquisition:
  - `locked` goes to 1 after the edge sampling the `CTRL_RUN`th consecutive token.
  - The first ungated output comes from the `din` sampled on the following edge.
- Lock loss: `locked` falls after the edge on which the window expires, and outputs are gated from the next edge.
- `bitslip` is high for exactly one cycle. Spacing between pulses is `SLIP_WAIT` + `SEARCH_LEN` cycles.
- Counter widths are $clog2(param+1) bits. No counter wraps; each is compared and cleared.

## Test plan
- Reset: hold `rst_pix_n`=0 with random `din`, then release. All outputs stay 0 and `locked`=0 until a token run arrives.
- Lock: feed 8×0x354 and then 0x2AB. `locked`=1 after the 8th token, and on the next cycle `ctrl`=11, `de`=0.
- Decode (locked): 0x100 gives `dout`=0x00; 0x200 gives 0xFF; 0x1FF gives 0x01. Each has `de`=1 with 1-cycle latency, and `ctrl` holds the prior value.
- Misalignment: feed only 0x1FF from reset.
  - `bitslip` pulses once at cycle 2048.
  - No pulse follows for 16+2048 cycles.
  - `locked` stays 0 and `de` stays 0.
- Loss of lock: lock, then feed 2048 data symbols with no run. `locked` falls after window expiry and `de` is forced 0. Restoring token runs relocks without any `bitslip`.
- Simultaneous events: arrange the 8th token on the same cycle the window expires in both SEARCH and LOCKED. The result is lock gained or kept, with no `bitslip`. Separately, reset mid-WAIT returns to SEARCH with no further pulse.

Source files
------------

// File: rtl/tmds_symbol_decoder.sv
// TMDS receive-side symbol decoder for one channel: recovers word alignment by
// bitslipping until control-token runs appear, then decodes pixel/control symbols.
module tmds_symbol_decoder #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 16
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_LEN + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_LEN - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Returns {is_token, ctrl_value}.
  function automatic logic [2:0] token_decode(input logic [9:0] q);
    case (q)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] data_decode(input logic [9:0] q);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = dp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    end
    return d;
  endfunction

  state_t              state_r, state_next_s;
  logic [RUN_W-1:0]    run_r, run_next_s;
  logic [WIN_W-1:0]    win_r, win_next_s;
  logic [SLIP_W-1:0]   slip_r, slip_next_s;
  logic                bitslip_r, locked_r;
  logic                de_r, de_next_s;
  logic [1:0]          ctrl_r, ctrl_next_s;
  logic [7:0]          dout_r, dout_next_s;
  logic [2:0]          tok_info_s;
  logic                tok_s;
  logic                run_hit_s;

  assign tok_info_s = token_decode(din);
  assign tok_s      = tok_info_s[2];
  // A run completes on the edge sampling the CTRL_RUN-th consecutive token.
  assign run_hit_s  = tok_s && (run_r >= RUN_LAST);

  // Next-state logic for the alignment FSM and its counters.
  always_comb begin
    state_next_s = state_r;
    run_next_s   = '0;
    win_next_s   = win_r;
    slip_next_s  = slip_r;

    if (state_r == ST_WAIT) begin
      run_next_s = '0;
    end else if (tok_s) begin
      run_next_s = (run_r == RUN_MAX) ? run_r : run_r + RUN_W'(1);
    end else begin
      run_next_s = '0;
    end

    case (state_r)
      ST_SEARCH: begin
        if (run_hit_s) begin
          state_next_s = ST_LOCKED;
          win_next_s   = '0;
        end else if (win_r == WIN_LAST) begin
          state_next_s = ST_WAIT;
          win_next_s   = '0;
          slip_next_s  = '0;
        end else begin
          win_next_s = win_r + WIN_W'(1);
        end
      end
      ST_WAIT: begin
        win_next_s = '0;
        if (slip_r == SLIP_LAST) begin
          state_next_s = ST_SEARCH;
          slip_next_s  = '0;
        end else begin
          slip_next_s = slip_r + SLIP_W'(1);
        end
      end
      ST_LOCKED: begin
        if (run_hit_s) begin
          win_next_s = '0;
        end else if (win_r == WIN_LAST) begin
          state_next_s = ST_SEARCH;
          win_next_s   = '0;
        end else begin
          win_next_s = win_r + WIN_W'(1);
        end
      end
      default: begin
        state_next_s = ST_SEARCH;
        run_next_s   = '0;
        win_next_s   = '0;
        slip_next_s  = '0;
      end
    endcase
  end

  // Alignment state, counters, bitslip pulse and lock flag.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_r   <= ST_SEARCH;
      run_r     <= '0;
      win_r     <= '0;
      slip_r    <= '0;
      bitslip_r <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      run_r     <= run_next_s;
      win_r     <= win_next_s;
      slip_r    <= slip_next_s;
      bitslip_r <= (state_r == ST_SEARCH) && (state_next_s == ST_WAIT);
      locked_r  <= (state_next_s == ST_LOCKED);
    end
  end

  // Symbol decode, gated by the pre-edge lock state.
  always_comb begin
    de_next_s   = 1'b0;
    ctrl_next_s = 2'b00;
    dout_next_s = 8'h00;
    if (state_r == ST_LOCKED) begin
      if (tok_s) begin
        ctrl_next_s = tok_info_s[1:0];
      end else begin
        de_next_s   = 1'b1;
        ctrl_next_s = ctrl_r;
        dout_next_s = data_decode(din);
      end
    end else begin
      de_next_s   = 1'b0;
      ctrl_next_s = 2'b00;
      dout_next_s = 8'h00;
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
      dout_r <= 8'h00;
    end else begin
      de_r   <= de_next_s;
      ctrl_r <= ctrl_next_s;
      dout_r <= dout_next_s;
    end
  end

  assign bitslip = bitslip_r;
  assign locked  = locked_r;
  assign de      = de_r;
  assign ctrl    = ctrl_r;
  assign dout    = dout_r;

endmodule
